// File: rtl/berzerk_nvram_arb.sv
`default_nettype none
// ============================================================================
//  Module   : berzerk_nvram_arb
//  Purpose  : Arbitrates a single-port NVRAM between the CPU and HPS ioctl
//             up/download, with a one-entry HPS pending buffer.
//  Revision : 1.0  initial release
// ============================================================================
module berzerk_nvram_arb #(
   parameter int AW = 10
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_din,
   output logic [7:0]    cpu_dout,
   output logic          cpu_ack,
   input  logic          hps_nvram,
   input  logic          hps_wr,
   input  logic          hps_rd,
   input  logic [AW-1:0] hps_addr,
   input  logic [7:0]    hps_din,
   output logic [7:0]    hps_dout,
   output logic          hps_wait,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [7:0]    ram_wdata,
   input  logic [7:0]    ram_rdata,
   output logic          busy,
   output logic          ovf
);

   localparam logic [2:0] c_IDLE     = 3'd0;
   localparam logic [2:0] c_CPU_ACC  = 3'd1;
   localparam logic [2:0] c_CPU_DONE = 3'd2;
   localparam logic [2:0] c_HPS_ACC  = 3'd3;
   localparam logic [2:0] c_HPS_DONE = 3'd4;

   logic [2:0]    r_state;
   logic          r_op_we;
   logic          r_pend;
   logic          r_pend_we;
   logic [AW-1:0] r_pend_addr;
   logic [7:0]    r_pend_din;
   logic          r_ovf;

   logic          w_strobe;
   logic          w_both;
   logic          w_accept;
   logic          w_drop;
   logic          w_hps_go;
   logic          w_hps_we;
   logic [AW-1:0] w_hps_addr;
   logic [7:0]    w_hps_din;

   assign w_strobe = hps_nvram & (hps_wr | hps_rd);
   assign w_both   = hps_nvram & hps_wr & hps_rd;
   assign w_accept = w_strobe & ~w_both & ~r_pend;
   assign w_drop   = w_both | (w_strobe & r_pend);

   // A strobe accepted while IDLE bypasses the buffer so HPS wins a same-cycle tie.
   assign w_hps_go   = r_pend | w_accept;
   assign w_hps_we   = r_pend ? r_pend_we   : hps_wr;
   assign w_hps_addr = r_pend ? r_pend_addr : hps_addr;
   assign w_hps_din  = r_pend ? r_pend_din  : hps_din;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state     <= c_IDLE;
         r_op_we     <= 1'b0;
         r_pend      <= 1'b0;
         r_pend_we   <= 1'b0;
         r_pend_addr <= '0;
         r_pend_din  <= 8'h00;
         r_ovf       <= 1'b0;
         cpu_ack     <= 1'b0;
         cpu_dout    <= 8'h00;
         hps_dout    <= 8'h00;
         ram_addr    <= '0;
         ram_wdata   <= 8'h00;
         ram_we      <= 1'b0;
      end else begin
         ram_we  <= 1'b0;
         cpu_ack <= 1'b0;

         if (w_drop) begin
            r_ovf <= 1'b1;
         end

         if (w_accept) begin
            r_pend      <= 1'b1;
            r_pend_we   <= hps_wr;
            r_pend_addr <= hps_addr;
            r_pend_din  <= hps_din;
         end

         case (r_state)
            c_IDLE: begin
               if (w_hps_go) begin
                  r_state   <= c_HPS_ACC;
                  r_op_we   <= w_hps_we;
                  ram_addr  <= w_hps_addr;
                  ram_wdata <= w_hps_din;
                  ram_we    <= w_hps_we;
               end else if (cpu_req && !cpu_ack) begin
                  // The ack cycle itself is masked; the CPU drops req one cycle later.
                  r_state   <= c_CPU_ACC;
                  r_op_we   <= cpu_we;
                  ram_addr  <= cpu_addr;
                  ram_wdata <= cpu_din;
                  ram_we    <= cpu_we;
               end
            end
            c_CPU_ACC: begin
               r_state <= c_CPU_DONE;
            end
            c_CPU_DONE: begin
               if (!r_op_we) begin
                  cpu_dout <= ram_rdata;
               end
               cpu_ack <= 1'b1;
               r_state <= c_IDLE;
            end
            c_HPS_ACC: begin
               r_state <= c_HPS_DONE;
            end
            c_HPS_DONE: begin
               if (!r_op_we) begin
                  hps_dout <= ram_rdata;
               end
               r_pend  <= 1'b0;
               r_state <= c_IDLE;
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   assign hps_wait = r_pend;
   assign busy     = (r_state != c_IDLE);
   assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: doc/berzerk_nvram_arb.md
BERZERK_NVRAM_ARB -- requirements
Module: berzerk_nvram_arb

Interface
REQ-001 SHALL have parameter AW, default 10, NVRAM address width (1 KB high-score/CMOS RAM).
REQ-002 SHALL have port clk_sys, in, 1: single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, in, 1: synchronous, active-high reset.
REQ-004 SHALL have port cpu_req, in, 1: CPU access request (level); the CPU holds it until cpu_ack.
REQ-005 SHALL have port cpu_we, in, 1: CPU write (1) or read (0); held with cpu_req.
REQ-006 SHALL have ports cpu_addr, in, AW and cpu_din, in, 8: CPU address and write data.
REQ-007 SHALL have ports cpu_dout, out, 8 and cpu_ack, out, 1: CPU read data and a one-cycle completion pulse.
REQ-008 SHALL have port hps_nvram, in, 1: HPS NVRAM session active (ioctl index 4).
REQ-009 SHALL have ports hps_wr, in, 1 and hps_rd, in, 1: single-cycle download-write and upload-read strobes.
REQ-010 SHALL have ports hps_addr, in, AW and hps_din, in, 8: HPS address and write data.
REQ-011 SHALL have ports hps_dout, out, 8 and hps_wait, out, 1: upload read data and the ioctl_wait back-pressure signal.
REQ-012 SHALL have ports ram_addr, out, AW; ram_we, out, 1; ram_wdata, out, 8; ram_rdata, in, 8: single-port RAM with 1-cycle synchronous read.
REQ-013 SHALL have ports busy, out, 1 (FSM not IDLE) and ovf, out, 1 (sticky HPS strobe overrun).

Function
REQ-014 SHALL accept HPS strobes only while hps_nvram=1; strobes with hps_nvram=0 are ignored.
REQ-015 SHALL latch hps_addr, hps_din and the operation type into a one-entry pending buffer on an accepted strobe.
REQ-016 SHALL assert hps_wait from the cycle after the strobe until the cycle after that operation completes.
REQ-017 SHALL ignore a strobe arriving while the pending buffer is full, and SHALL set ovf=1 until reset.
REQ-018 SHALL ignore simultaneous hps_wr and hps_rd, and SHALL set ovf=1.
REQ-019 SHALL implement the FSM states IDLE, CPU_ACC, CPU_DONE, HPS_ACC and HPS_DONE.
REQ-020 SHALL use the following IDLE priority: pending HPS op goes to HPS_ACC; else cpu_req=1 goes to CPU_ACC; else stay in IDLE.
REQ-021 SHALL never preempt an access in progress, and SHALL re-arbitrate only in IDLE.
REQ-022 In ACC states, SHALL register ram_addr and ram_wdata from the selected source and set ram_we = op is write, for exactly one cycle.
REQ-023 SHALL force ram_we=0 in every non-ACC state.
REQ-024 In DONE states, SHALL capture ram_rdata into cpu_dout or hps_dout for reads, and leave it unchanged for writes; the next state is IDLE.
REQ-025 SHALL pulse cpu_ack for 1 cycle, 3 cycles after cpu_req is first sampled in IDLE, with cpu_dout valid in that cycle and held until the next CPU read.
REQ-026 SHALL require cpu_req to drop in the cycle after cpu_ack; if it is still high, a new access starts from IDLE.
REQ-027 SHALL clear the HPS pending buffer on the DONE-to-IDLE transition.
REQ-028 SHALL deassert hps_wait in the first IDLE cycle after completion, with hps_dout valid in that cycle.
REQ-029 While hps_nvram=1 and HPS ops are continuous, the CPU is starved; this is the intended behaviour, since the CPU is held in reset during download.
REQ-030 Falling hps_nvram with an op pending SHALL still complete that op.

Reset
REQ-031 While reset=1 at a clock edge: state=IDLE, pending cleared, ovf=0, cpu_ack=0, hps_wait=0, ram_we=0, ram_addr=0, ram_wdata=0, cpu_dout=0, hps_dout=0, busy=0.
REQ-032 A reset sampled mid-access SHALL abort it; ram_we is low from the cycle after reset is sampled, and no ack is issued.

Verification
REQ-033 CPU write then read: cpu_req=1, cpu_we=1, addr 0x05A, din 0x3C -> ram_we high 1 cycle, ack at cycle 3; read of 0x05A -> cpu_dout=0x3C with ack at cycle 3.
REQ-034 HPS download: hps_nvram=1, hps_wr strobes every 4 cycles to addresses 0x000..0x3FF with data=addr[7:0] -> all 1024 written, ovf=0, hps_wait pulses each op.
REQ-035 Contention: cpu_req and hps_wr arrive in the same cycle -> HPS access first, CPU ack 3 cycles later than uncontended.
REQ-036 Overrun: two hps_rd strobes in consecutive cycles -> second ignored, ovf=1 until reset, first read returns the correct byte.
REQ-037 Reset mid-op: reset asserted during CPU_ACC of a write -> no cpu_ack, all outputs 0 next cycle, next request serviced normally.
REQ-038 Upload: hps_rd at address 0x3FF after CPU wrote 0xA5 there -> hps_dout=0xA5 when hps_wait falls.
